// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter for up to MASTER_NUM masters.
// Registered one-hot grant plus an address/data-phase ownership pipeline that
// only advances on HREADY. Grant is frozen during fixed-length bursts, locked
// sequences and (optionally time-limited) undefined-length INCR bursts.
// Optional feature macro: AHB_ARB_TIMEOUT_EN enables the INCR beat timeout and
// the TIMEOUT_BEATS parameter.
module ahb_arbiter #(
  parameter int MASTER_NUM     = 4,
  parameter int DEFAULT_MASTER = 0
`ifdef AHB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_BEATS  = 16
`endif
) (
  input  logic                          ahb_clk_in,
  input  logic                          ahb_rst_in,
  input  logic [MASTER_NUM-1:0]         ahb_busreq_in,
  input  logic [MASTER_NUM-1:0]         ahb_lock_in,
  input  logic [1:0]                    ahb_trans_in,
  input  logic [2:0]                    ahb_burst_in,
  input  logic                          ahb_ready_in,
  output logic [MASTER_NUM-1:0]         ahb_grant_out,
  output logic [$clog2(MASTER_NUM)-1:0] ahb_master_out,
  output logic [$clog2(MASTER_NUM)-1:0] ahb_master_data_out,
  output logic                          ahb_mastlock_out
);

  localparam int IDX_W = $clog2(MASTER_NUM);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;
  localparam logic [2:0] BURST_INCR   = 3'd1;

  localparam logic [IDX_W-1:0]      DEF_IDX   = IDX_W'(DEFAULT_MASTER);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(MASTER_NUM - 1);
  localparam logic [MASTER_NUM-1:0] GRANT_ONE = MASTER_NUM'(1);
  localparam logic [MASTER_NUM-1:0] DEF_GRANT = GRANT_ONE << DEF_IDX;

  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic [4:0]       cnt;
  logic [4:0]       burst_len_m1;
  logic             fixed_start;
  logic             h1;
  logic             h2;
  logic             h3;
  logic             h3_eff;
  logic             arb_en;

  // Encode the one-hot grant into the index of the granted master.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (ahb_grant_out[i]) gnt_idx = gnt_idx | IDX_W'(i);
    end
  end

  // Round-robin search starting one past the pointer; the current holder is
  // visited last so it only keeps the bus when nobody else asks.
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int i = 0; i < MASTER_NUM; i++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && ahb_busreq_in[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Beats-minus-one for a fixed-length burst; SINGLE and INCR give zero.
  always_comb begin
    case (ahb_burst_in[2:1])
      2'b01:   burst_len_m1 = 5'd3;
      2'b10:   burst_len_m1 = 5'd7;
      2'b11:   burst_len_m1 = 5'd15;
      default: burst_len_m1 = 5'd0;
    endcase
  end

  assign fixed_start = (ahb_trans_in == TRANS_NONSEQ) && (ahb_burst_in[2:1] != 2'b00);

  // A final SEQ seen with cnt==1 releases the hold in that same cycle, giving
  // a bubble-free handover at the end of a fixed burst.
  assign h1 = (cnt > 5'd1) ||
              ((cnt == 5'd1) && (ahb_trans_in != TRANS_SEQ)) ||
              fixed_start;
  assign h2 = ahb_lock_in[gnt_idx] && ahb_busreq_in[gnt_idx];
  assign h3 = (ahb_burst_in == BURST_INCR) &&
              (ahb_trans_in != TRANS_IDLE) &&
              ahb_busreq_in[gnt_idx];

`ifdef AHB_ARB_TIMEOUT_EN
  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_BEATS - 1);

  logic [4:0] incr_cnt;
  logic       other_req;
  logic       timeout_hit;

  assign other_req   = |(ahb_busreq_in & ~ahb_grant_out);
  assign timeout_hit = h3 && (incr_cnt == TIMEOUT_LAST) && other_req;
  assign h3_eff      = h3 && !timeout_hit;

  // Count accepted INCR beats; saturate at the limit until someone else asks,
  // and restart once the forced re-arbitration has actually happened.
  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      incr_cnt <= '0;
    end else if (!h3) begin
      incr_cnt <= '0;
    end else if (ahb_ready_in) begin
      if (timeout_hit && !h1 && !h2) begin
        incr_cnt <= '0;
      end else if (((ahb_trans_in == TRANS_NONSEQ) || (ahb_trans_in == TRANS_SEQ)) &&
                   (incr_cnt != TIMEOUT_LAST)) begin
        incr_cnt <= incr_cnt + 5'd1;
      end
    end
  end
`else
  assign h3_eff = h3;
`endif

  assign arb_en = ahb_ready_in && !(h1 || h2 || h3_eff);

  // Remaining-beat counter of the current fixed-length burst.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      cnt <= '0;
    end else if (ahb_ready_in) begin
      case (ahb_trans_in)
        TRANS_NONSEQ: cnt <= burst_len_m1;
        TRANS_SEQ:    if (cnt != 5'd0) cnt <= cnt - 5'd1;
        TRANS_IDLE:   cnt <= '0;
        TRANS_BUSY:   cnt <= cnt;
        default:      cnt <= cnt;
      endcase
    end
  end

  // Register the arbitration winner as the new grant and round-robin pointer.
  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      ahb_grant_out <= DEF_GRANT;
      rr_ptr        <= DEF_IDX;
    end else if (arb_en) begin
      ahb_grant_out <= GRANT_ONE << winner;
      rr_ptr        <= winner;
    end
  end

  // Ownership pipeline: grant -> address phase -> data phase, on HREADY only.
  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      ahb_master_out      <= DEF_IDX;
      ahb_master_data_out <= DEF_IDX;
      ahb_mastlock_out    <= 1'b0;
    end else if (ahb_ready_in) begin
      ahb_master_out      <= gnt_idx;
      ahb_master_data_out <= ahb_master_out;
      ahb_mastlock_out    <= ahb_lock_in[gnt_idx];
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scoreboard bench for ahb_arbiter (4 masters).
// The driver applies one cycle of inputs per step and queues the expected
// post-edge outputs; a monitor on the falling edge pops and compares them.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR   = 3'd1;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] INCR8  = 3'd5;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] mo;
    logic [1:0] md;
    logic       ml;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] busreq = '0;
  logic [3:0] lock = '0;
  logic [1:0] trans = IDLE;
  logic [2:0] burst = SINGLE;
  logic       ready = 1'b1;
  logic [3:0] grant;
  logic [1:0] master;
  logic [1:0] master_data;
  logic       mastlock;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ahb_arbiter #(
    .MASTER_NUM(4),
    .DEFAULT_MASTER(0)
`ifdef AHB_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_BEATS(4)
`endif
  ) dut (
    .ahb_clk_in         (clk),
    .ahb_rst_in         (rst),
    .ahb_busreq_in      (busreq),
    .ahb_lock_in        (lock),
    .ahb_trans_in       (trans),
    .ahb_burst_in       (burst),
    .ahb_ready_in       (ready),
    .ahb_grant_out      (grant),
    .ahb_master_out     (master),
    .ahb_master_data_out(master_data),
    .ahb_mastlock_out   (mastlock)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: apply inputs, let the edge happen, queue expected outputs.
  task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] em, input logic [1:0] ed,
                      input logic el, input string nm);
    busreq = req;
    lock   = lk;
    trans  = tr;
    burst  = bu;
    ready  = rdy;
    @(posedge clk);
    #1;
    exp_q.push_back('{eg, em, ed, el, nm});
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, "_grant"},    32'(grant),       32'(e.grant));
      check({e.name, "_master"},   32'(master),      32'(e.mo));
      check({e.name, "_data"},     32'(master_data), 32'(e.md));
      check({e.name, "_mastlock"}, 32'(mastlock),    32'(e.ml));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle bus
    rst = 1'b1;
    step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, "reset0");
    step(4'b1111, 4'b1111, NONSEQ, INCR8, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, "reset1");
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, "idle_hold");

    // Masters 1 and 3 together: round robin from pointer 0
    step(4'b1010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0, "rr_first_m1");
    step(4'b1010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd1, 2'd0, 1'b0, "rr_next_m3");
    step(4'b1000, 4'b0000, NONSEQ, SINGLE, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0, "m1_single");
    step(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0, "m3_owner");
    step(4'b0001, 4'b0000, IDLE, SINGLE, 1'b0, 4'b1000, 2'd3, 2'd3, 1'b0, "ready_low_hold");
    step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd3, 2'd3, 1'b0, "no_req_default");
    step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 2'd0, 2'd3, 1'b0, "grant_m2");

    // Master 2 INCR8 with master 0 waiting and two wait states mid-burst
    step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0, "m2_addr");
    step(4'b0101, 4'b0000, NONSEQ, INCR8, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, "incr8_beat1");
    for (int b = 2; b <= 3; b++)
      step(4'b0101, 4'b0000, SEQ, INCR8, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, "incr8_hold");
    for (int w = 0; w < 2; w++)
      step(4'b0101, 4'b0000, SEQ, INCR8, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0, "incr8_wait");
    for (int b = 4; b <= 7; b++)
      step(4'b0101, 4'b0000, SEQ, INCR8, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, "incr8_hold");
    step(4'b0101, 4'b0000, SEQ, INCR8, 1'b1, 4'b0001, 2'd2, 2'd2, 1'b0, "incr8_last");
    step(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd2, 1'b0, "m0_addr");

    // Master 1 INCR4 cut short by IDLE after two beats
    step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0, "grant_m1");
    step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0, "m1_addr");
    step(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, "incr4_beat1");
    step(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, "incr4_beat2");
    step(4'b0100, 4'b0000, IDLE, INCR4, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, "incr4_idle");
    step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 2'd1, 2'd1, 1'b0, "after_abort");

    // Master 3 locked across three SINGLEs while masters 0 and 1 request
    step(4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd2, 2'd1, 1'b0, "grant_m3_lock");
    step(4'b1011, 4'b1000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b1, "m3_lock_addr");
    for (int s = 0; s < 3; s++)
      step(4'b1011, 4'b1000, NONSEQ, SINGLE, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1, "lock_single");
    step(4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd3, 2'd3, 1'b0, "lock_release");
    step(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0, "m0_addr2");

    // Master 0 undefined-length INCR while master 2 requests
    step(4'b0101, 4'b0000, NONSEQ, INCR, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, "incr_beat1");
`ifdef AHB_ARB_TIMEOUT_EN
    for (int b = 2; b <= 3; b++)
      step(4'b0101, 4'b0000, SEQ, INCR, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, "incr_beat");
    step(4'b0101, 4'b0000, SEQ, INCR, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0, "incr_timeout");
`else
    for (int b = 2; b <= 32; b++)
      step(4'b0101, 4'b0000, SEQ, INCR, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, "incr_no_timeout");
`endif

    // Let the monitor drain the remaining expectations (bounded)
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin AHB bus arbiter that shares one AHB address/data path between up to MASTER_NUM masters.
- Sits ahead of the AHB decoder. Its owner index drives the master-side address/control mux, and its data-phase index drives the write-data mux.
- Grant is never moved in the middle of a fixed-length burst or a locked sequence.
- Registered grant and ownership outputs; handover follows the AHB HREADY rule.

Parameters:
MASTER_NUM, 4, number of requesting masters (2..8)
DEFAULT_MASTER, 0, index granted when nobody requests
TIMEOUT_BEATS, 16, max accepted beats of an undefined-length INCR before forced re-arbitration (used only with AHB_ARB_TIMEOUT_EN)

Ports:
ahb_clk_in  input  1  bus clock; all logic on rising edge
ahb_rst_in  input  1  synchronous, active-high reset
ahb_busreq_in  input  MASTER_NUM  per-master bus request
ahb_lock_in  input  MASTER_NUM  per-master locked-transfer request
ahb_trans_in  input  2  HTRANS of current address owner (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
ahb_burst_in  input  3  HBURST of current address owner (0 SINGLE, 1 INCR, 2/3 4-beat, 4/5 8-beat, 6/7 16-beat)
ahb_ready_in  input  1  HREADY from the slave mux
ahb_grant_out  output  MASTER_NUM  one-hot grant
ahb_master_out  output  $clog2(MASTER_NUM)  address-phase owner index
ahb_master_data_out  output  $clog2(MASTER_NUM)  data-phase owner index
ahb_mastlock_out  output  1  current address phase is locked

Behaviour:
- Interface: one clock, ahb_clk_in. Reset is ahb_rst_in, synchronous and active-high.
- Reset values:
  - ahb_grant_out is one-hot at DEFAULT_MASTER.
  - ahb_master_out and ahb_master_data_out are DEFAULT_MASTER.
  - ahb_mastlock_out is 0.
  - Beat counter is 0 and the round-robin pointer is DEFAULT_MASTER.
  - Reset mid-burst or mid-lock aborts immediately to these values.
- Ownership pipeline: on each edge with ahb_ready_in=1:
  - ahb_master_out takes the index of ahb_grant_out.
  - ahb_master_data_out takes the old ahb_master_out.
  - ahb_mastlock_out takes ahb_lock_in[granted index].
  - With ahb_ready_in=0, all three hold.
- Beat counter cnt (5 bits), updated only when ahb_ready_in=1:
  - NONSEQ with a 4/8/16-beat burst loads cnt = beats-1.
  - SEQ with cnt>0 decrements.
  - IDLE clears cnt (early termination).
  - BUSY holds.
  - NONSEQ with SINGLE or INCR clears cnt.
- Hold conditions (grant frozen):
  - H1: cnt>1, or cnt==1 with trans≠SEQ, or the current-cycle NONSEQ starts a fixed burst of 4 or more beats.
  - H2 (lock): ahb_lock_in and ahb_busreq_in of the owner are both 1.
  - H3 (INCR): ahb_burst_in==INCR, trans ∈ {NONSEQ, SEQ, BUSY}, and the owner's busreq is 1.
- Arbitration: evaluated each cycle with ahb_ready_in=1 and no hold condition.
  - Winner is the first requesting master scanning from (pointer+1) mod MASTER_NUM upward, wrapping.
  - If the only requester is the current owner, it keeps the grant.
  - If no master requests, the winner is DEFAULT_MASTER.
  - ahb_grant_out is registered with the winner at the next edge; the pointer updates to the winner.
  - With ahb_ready_in=0, grant holds regardless of requests.
- Latency:
  - A request arriving during a free, ready cycle is granted at the next edge (1 cycle).
  - The new master owns the address phase after its first ready edge while granted.
  - Last beat of a fixed burst: the final SEQ accepted with cnt==1 permits arbitration in that same cycle, so there is no idle handover bubble.
- Simultaneous events:
  - A locked owner beats every other request.
  - A lock request from a non-owner has no priority; it only matters once that master owns the bus.
  - ahb_busreq_in deasserting during a fixed burst does not release the grant until the burst completes or IDLE is seen.
- Grant is always exactly one-hot. No state is left undefined for MASTER_NUM that is not a power of two; indices ≥ MASTER_NUM are never produced.

Optional Feature:
AHB_ARB_TIMEOUT_EN
- Defined:
  - A 5-bit incr_cnt counts ready-accepted NONSEQ/SEQ beats while H3 holds; it is cleared whenever H3 is false.
  - When incr_cnt reaches TIMEOUT_BEATS-1 with another master requesting, H3 is ignored for that cycle and arbitration proceeds; incr_cnt then clears.
  - The round-robin order automatically puts the old owner last.
  - Timeout never overrides H1 or H2.
- Undefined: no incr_cnt. An INCR owner keeps the grant while H3 holds, without limit.

Test Plan:
- Reset, then no requests → grant=0001, master_out=0, data_out=0, mastlock=0; hold 5 cycles unchanged.
- Masters 1 and 3 request simultaneously, ready=1, pointer=0 → grant 0010 next edge. Master 1 drops after one SINGLE → grant 1000 next edge; master_data_out lags master_out by one ready edge.
- Master 2 issues INCR8 (NONSEQ then 7 SEQ) while master 0 requests, with ready low for 2 cycles mid-burst → grant stays 0100 for all 8 beats. Grant becomes 0001 at the edge after the 8th accepted beat.
- Master 1 INCR4 terminated by IDLE after 2 beats → cnt cleared, next requester granted on the following edge.
- Master 3 with lock=1 and busreq=1 across three SINGLEs while masters 0 and 1 request → grant stays 1000 and mastlock=1 each beat. After lock drops → grant 0001.
- With AHB_ARB_TIMEOUT_EN, TIMEOUT_BEATS=4: master 0 runs an endless INCR while master 2 requests → grant moves to 0100 after exactly 4 accepted beats. Without the macro, grant stays 0001 for 32 beats.
